// File: rtl/fe_pred_stage.sv
// Fetch stage with a direct-mapped branch target buffer.
// Holds the PC, looks it up in the BTB to predict the next PC, and
// registers the fetched instruction into the FE latch for decode.
// Handshake: fe_valid qualifies the FE latch contents. de_stall is the
// backpressure from decode: while it is high the PC and the whole latch
// hold. agex_mispred flushes (fe_valid drops) and redirects even under
// stall. BTB training from agex is independent of both.
module fe_pred_stage #(
    parameter int               DBITS        = 32,
    parameter logic [DBITS-1:0] STARTPC      = DBITS'(32'h200),
    parameter int               BTB_IDX_BITS = 4,
    parameter int               INSTSIZE     = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [DBITS-1:0] imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             de_stall,
    input  logic             agex_br_valid,
    input  logic [DBITS-1:0] agex_br_pc,
    input  logic [DBITS-1:0] agex_br_target,
    input  logic             agex_br_taken,
    input  logic             agex_mispred,
    input  logic [DBITS-1:0] agex_redirect_pc,
    output logic             fe_valid,
    output logic [31:0]      fe_inst,
    output logic [DBITS-1:0] fe_pc,
    output logic [DBITS-1:0] fe_pcplus,
    output logic             fe_pred_taken,
    output logic [DBITS-1:0] fe_pred_target,
    output logic [DBITS-1:0] fe_inst_count
);

    localparam int DEPTH = 1 << BTB_IDX_BITS;
    localparam int TAGW  = DBITS - BTB_IDX_BITS - 2;

    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] inst_cnt;   // sequence number the next latched instruction gets

    // BTB storage; only the valid bits need a reset
    logic             btb_valid  [DEPTH];
    logic [TAGW-1:0]  btb_tag    [DEPTH];
    logic [DBITS-1:0] btb_target [DEPTH];
    logic [1:0]       btb_ctr    [DEPTH];

    logic [BTB_IDX_BITS-1:0] l_idx;
    logic [TAGW-1:0]         l_tag;
    logic                    l_hit;
    logic                    pred_taken;
    logic [DBITS-1:0]        pc_plus;
    logic [DBITS-1:0]        next_pc;

    logic [BTB_IDX_BITS-1:0] u_idx;
    logic [TAGW-1:0]         u_tag;
    logic                    u_hit;

    assign imem_addr = pc;
    assign l_idx     = pc[BTB_IDX_BITS+1:2];
    assign l_tag     = pc[DBITS-1:BTB_IDX_BITS+2];
    assign u_idx     = agex_br_pc[BTB_IDX_BITS+1:2];
    assign u_tag     = agex_br_pc[DBITS-1:BTB_IDX_BITS+2];

    // Lookup reads the arrays before this cycle's update lands, so a
    // same-index update only becomes visible on the following cycle.
    always_comb begin
        l_hit      = btb_valid[l_idx] && (btb_tag[l_idx] == l_tag);
        pred_taken = l_hit && btb_ctr[l_idx][1];
        pc_plus    = pc + DBITS'(INSTSIZE);
        next_pc    = pred_taken ? btb_target[l_idx] : pc_plus;
    end

    // Hit check for the resolved branch reported by agex
    always_comb begin
        u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
    end

    // PC register and FE latch: reset > mispredict flush > stall hold > advance
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= STARTPC;
            fe_valid       <= 1'b0;
            fe_inst        <= '0;
            fe_pc          <= '0;
            fe_pcplus      <= '0;
            fe_pred_taken  <= 1'b0;
            fe_pred_target <= '0;
            fe_inst_count  <= DBITS'(1);
            inst_cnt       <= DBITS'(1);
        end else if (agex_mispred) begin
            pc       <= agex_redirect_pc;
            fe_valid <= 1'b0;
        end else if (!de_stall) begin
            pc             <= next_pc;
            fe_valid       <= 1'b1;
            fe_inst        <= imem_data;
            fe_pc          <= pc;
            fe_pcplus      <= pc_plus;
            fe_pred_taken  <= pred_taken;
            fe_pred_target <= next_pc;
            fe_inst_count  <= inst_cnt;
            inst_cnt       <= inst_cnt + DBITS'(1);
        end
    end

    // BTB valid bits: cleared on reset, set when a taken branch allocates
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) btb_valid[i] <= 1'b0;
        end else if (agex_br_valid && !u_hit && agex_br_taken) begin
            btb_valid[u_idx] <= 1'b1;
        end
    end

    // BTB payload: counter training and target refresh on hit, allocation on taken miss
    always_ff @(posedge clk) begin
        if (!reset && agex_br_valid) begin
            if (u_hit) begin
                if (agex_br_taken) begin
                    btb_target[u_idx] <= agex_br_target;
                    if (btb_ctr[u_idx] != 2'b11) btb_ctr[u_idx] <= btb_ctr[u_idx] + 2'd1;
                end else if (btb_ctr[u_idx] != 2'b00) begin
                    btb_ctr[u_idx] <= btb_ctr[u_idx] - 2'd1;
                end
            end else if (agex_br_taken) begin
                btb_tag[u_idx]    <= u_tag;
                btb_target[u_idx] <= agex_br_target;
                btb_ctr[u_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fe_pred_stage.sv
// Bench for fe_pred_stage: directed vector table plus randomized traffic
// against a behavioural model of the fetch/predict rules.
module tb_fe_pred_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        de_stall;
    logic        agex_br_valid;
    logic [31:0] agex_br_pc;
    logic [31:0] agex_br_target;
    logic        agex_br_taken;
    logic        agex_mispred;
    logic [31:0] agex_redirect_pc;
    logic        fe_valid;
    logic [31:0] fe_inst;
    logic [31:0] fe_pc;
    logic [31:0] fe_pcplus;
    logic        fe_pred_taken;
    logic [31:0] fe_pred_target;
    logic [31:0] fe_inst_count;

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    fe_pred_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .de_stall         (de_stall),
        .agex_br_valid    (agex_br_valid),
        .agex_br_pc       (agex_br_pc),
        .agex_br_target   (agex_br_target),
        .agex_br_taken    (agex_br_taken),
        .agex_mispred     (agex_mispred),
        .agex_redirect_pc (agex_redirect_pc),
        .fe_valid         (fe_valid),
        .fe_inst          (fe_inst),
        .fe_pc            (fe_pc),
        .fe_pcplus        (fe_pcplus),
        .fe_pred_taken    (fe_pred_taken),
        .fe_pred_target   (fe_pred_target),
        .fe_inst_count    (fe_inst_count)
    );

    // instruction memory: a fixed scramble of the address
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    assign imem_data = inst_of(imem_addr);

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_inst, m_fpc, m_fplus, m_ptgt, m_cnt, m_nxt;
    logic        m_v, m_pt;
    bit          m_bv   [16];
    logic [31:0] m_btag [16];
    logic [31:0] m_btgt [16];
    int          m_bctr [16];

    task automatic model_step();
        int          idx, ui;
        logic [31:0] tg, ut, ppl, npc;
        bit          hit, pt;
        if (reset) begin
            m_pc = 32'h200; m_v = 1'b0; m_inst = '0; m_fpc = '0; m_fplus = '0;
            m_pt = 1'b0; m_ptgt = '0; m_cnt = 32'd1; m_nxt = 32'd1;
            for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
            return;
        end
        idx = int'((m_pc >> 2) & 32'hF);
        tg  = m_pc >> 6;
        hit = m_bv[idx] && (m_btag[idx] == tg);
        pt  = hit && (m_bctr[idx] >= 2);
        ppl = m_pc + 32'd4;
        npc = pt ? m_btgt[idx] : ppl;
        if (agex_mispred) begin
            m_pc = agex_redirect_pc;
            m_v  = 1'b0;
        end else if (!de_stall) begin
            m_v = 1'b1; m_inst = inst_of(m_pc); m_fpc = m_pc; m_fplus = ppl;
            m_pt = pt; m_ptgt = npc; m_cnt = m_nxt; m_nxt = m_nxt + 32'd1;
            m_pc = npc;
        end
        if (agex_br_valid) begin
            ui = int'((agex_br_pc >> 2) & 32'hF);
            ut = agex_br_pc >> 6;
            if (m_bv[ui] && m_btag[ui] == ut) begin
                if (agex_br_taken) begin
                    m_bctr[ui] = (m_bctr[ui] + 1 > 3) ? 3 : m_bctr[ui] + 1;
                    m_btgt[ui] = agex_br_target;
                end else begin
                    m_bctr[ui] = (m_bctr[ui] - 1 < 0) ? 0 : m_bctr[ui] - 1;
                end
            end else if (agex_br_taken) begin
                m_bv[ui] = 1'b1; m_btag[ui] = ut; m_btgt[ui] = agex_br_target; m_bctr[ui] = 2;
            end
        end
    endtask

    // ---------------- driver / checker ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic bv,
                         input logic [31:0] bpc, input logic [31:0] btgt, input logic btk,
                         input logic mp, input logic [31:0] rpc);
        reset = rst; de_stall = stall; agex_br_valid = bv; agex_br_pc = bpc;
        agex_br_target = btgt; agex_br_taken = btk; agex_mispred = mp; agex_redirect_pc = rpc;
    endtask

    // one clock: model follows the same inputs, outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        rst, stall, bv;
        logic [31:0] bpc, btgt;
        logic        btk, mp;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_tg, e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic stall, input logic bv,
                       input logic [31:0] bpc, input logic [31:0] btgt, input logic btk,
                       input logic mp, input logic [31:0] rpc,
                       input logic [31:0] e_addr, input logic e_v, input logic [31:0] e_pc,
                       input logic e_pt, input logic [31:0] e_tg, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.bv = bv; v.bpc = bpc; v.btgt = btgt; v.btk = btk;
        v.mp = mp; v.rpc = rpc; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc;
        v.e_pt = e_pt; v.e_tg = e_tg; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h200 + 32'(4 * $urandom_range(0, 47));
    endfunction

    initial begin
        logic [31:0] e_plus, e_inst;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);

        //    rst stl bv  br_pc    br_tgt   tk mp redirect   addr     v  fe_pc    pt tgt      cnt
        add(1, 0, 0, 0,       0,       0, 0, 0,        'h200,   0, 0,       0, 0,       1);  // reset
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h204,   1, 'h200,   0, 'h204,   1);  // sequential
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h208,   1, 'h204,   0, 'h208,   2);
        add(0, 1, 0, 0,       0,       0, 0, 0,        'h208,   1, 'h204,   0, 'h208,   2);  // stall
        add(0, 1, 0, 0,       0,       0, 0, 0,        'h208,   1, 'h204,   0, 'h208,   2);
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h20C,   1, 'h208,   0, 'h20C,   3);
        add(0, 0, 1, 'h208,   'h300,   1, 0, 0,        'h210,   1, 'h20C,   0, 'h210,   4);  // allocate 208
        add(0, 0, 0, 0,       0,       0, 1, 'h208,    'h208,   0, 'h20C,   0, 'h210,   4);  // refetch 208
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h300,   1, 'h208,   1, 'h300,   5);  // predicted taken
        add(0, 0, 1, 'h208,   0,       0, 1, 'h208,    'h208,   0, 'h208,   1, 'h300,   5);  // ctr 2->1
        add(0, 1, 1, 'h208,   0,       0, 0, 0,        'h208,   0, 'h208,   1, 'h300,   5);  // ctr 1->0 under stall
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h20C,   1, 'h208,   0, 'h20C,   6);  // now not taken
        add(0, 1, 0, 0,       0,       0, 1, 'h400,    'h400,   0, 'h208,   0, 'h20C,   6);  // mispred under stall
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h404,   1, 'h400,   0, 'h404,   7);
        add(0, 0, 1, 'h208,   'h300,   1, 0, 0,        'h408,   1, 'h404,   0, 'h408,   8);  // ctr 0->1
        add(0, 0, 1, 'h208,   'h300,   1, 0, 0,        'h40C,   1, 'h408,   0, 'h40C,   9);  // ctr 1->2, 408 aliases
        add(0, 0, 0, 0,       0,       0, 1, 'h248,    'h248,   0, 'h408,   0, 'h40C,   9);
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h24C,   1, 'h248,   0, 'h24C,   10); // alias miss
        add(0, 0, 0, 0,       0,       0, 1, 'h208,    'h208,   0, 'h248,   0, 'h24C,   10);
        add(0, 0, 1, 'h248,   'h500,   1, 0, 0,        'h300,   1, 'h208,   1, 'h300,   11); // same-cycle: old entry
        add(0, 0, 0, 0,       0,       0, 1, 'h208,    'h208,   0, 'h208,   1, 'h300,   11);
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h20C,   1, 'h208,   0, 'h20C,   12); // replaced -> miss
        add(0, 0, 0, 0,       0,       0, 1, 'h248,    'h248,   0, 'h208,   0, 'h20C,   12);
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h500,   1, 'h248,   1, 'h500,   13); // new entry hits
        add(1, 1, 1, 'h200,   'h700,   1, 1, 'h400,    'h200,   0, 0,       0, 0,       1);  // reset wins
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h204,   1, 'h200,   0, 'h204,   1);  // no leaked update
        add(0, 0, 0, 0,       0,       0, 1, 'h248,    'h248,   0, 'h200,   0, 'h204,   1);
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h24C,   1, 'h248,   0, 'h24C,   2);  // BTB cleared
        add(0, 0, 0, 0,       0,       0, 1, 'hFFFFFFFC,'hFFFFFFFC,0,'h248, 0, 'h24C,   2);
        add(0, 0, 0, 0,       0,       0, 0, 0,        'h0,     1, 'hFFFFFFFC,0,'h0,    3);  // PC wrap

        // ---------------- directed table ----------------
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].bv, tbl[i].bpc, tbl[i].btgt,
                  tbl[i].btk, tbl[i].mp, tbl[i].rpc);
            tick();
            e_plus = (tbl[i].rst || tbl[i].e_cnt == 32'd1 && !tbl[i].e_v && tbl[i].e_pc == 0)
                     ? 32'h0 : tbl[i].e_pc + 32'd4;
            e_inst = (e_plus == 32'h0 && tbl[i].e_pc == 32'h0) ? 32'h0 : inst_of(tbl[i].e_pc);
            check($sformatf("v%0d.imem_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("v%0d.fe_valid", i), {31'b0, fe_valid}, {31'b0, tbl[i].e_v});
            check($sformatf("v%0d.fe_pc", i), fe_pc, tbl[i].e_pc);
            check($sformatf("v%0d.fe_pcplus", i), fe_pcplus, e_plus);
            check($sformatf("v%0d.fe_inst", i), fe_inst, e_inst);
            check($sformatf("v%0d.fe_pred_taken", i), {31'b0, fe_pred_taken}, {31'b0, tbl[i].e_pt});
            check($sformatf("v%0d.fe_pred_target", i), fe_pred_target, tbl[i].e_tg);
            check($sformatf("v%0d.fe_inst_count", i), fe_inst_count, tbl[i].e_cnt);
        end

        // ---------------- randomized traffic vs model ----------------
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1),
                  rand_pc(), rand_pc(), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 7) == 0), rand_pc());
            tick();
            check("rnd.imem_addr", imem_addr, m_pc);
            check("rnd.fe_valid", {31'b0, fe_valid}, {31'b0, m_v});
            check("rnd.fe_pc", fe_pc, m_fpc);
            check("rnd.fe_pcplus", fe_pcplus, m_fplus);
            check("rnd.fe_inst", fe_inst, m_inst);
            check("rnd.fe_pred_taken", {31'b0, fe_pred_taken}, {31'b0, m_pt});
            check("rnd.fe_pred_target", fe_pred_target, m_ptgt);
            check("rnd.fe_inst_count", fe_inst_count, m_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fe_pred_stage.md
FE_PRED_STAGE -- requirements
Module: fe_pred_stage

Interface
Parameters:
REQ-001 SHALL have parameter DBITS, default 32, the PC/data width.
REQ-002 SHALL have parameter STARTPC, default 32'h200, the PC loaded on reset.
REQ-003 SHALL have parameter BTB_IDX_BITS, default 4, so BTB depth is 2**BTB_IDX_BITS entries.
REQ-004 SHALL have parameter INSTSIZE, default 4, the PC increment in bytes.
Ports:
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port imem_addr, output, DBITS: equals the current PC register.
REQ-008 SHALL have port imem_data, input, 32: instruction at imem_addr, valid in the same cycle.
REQ-009 SHALL have port de_stall, input, 1: decode cannot accept a new instruction.
REQ-010 SHALL have port agex_br_valid, input, 1: a resolved control-flow instruction is reported.
REQ-011 SHALL have ports agex_br_pc and agex_br_target, inputs, DBITS each: the PC and actual target of the resolved branch.
REQ-012 SHALL have port agex_br_taken, input, 1: the actual branch direction.
REQ-013 SHALL have port agex_mispred, input, 1: redirect required.
REQ-014 SHALL have port agex_redirect_pc, input, DBITS: the correct next PC.
REQ-015 SHALL have output fe_valid (1), fe_inst (32), fe_pc (DBITS), fe_pcplus (DBITS), fe_pred_taken (1), fe_pred_target (DBITS) and fe_inst_count (DBITS), all registered, forming the FE latch.

Function
REQ-016 SHALL split the PC as index = PC[BTB_IDX_BITS+1:2], tag = PC[DBITS-1:BTB_IDX_BITS+2]; each BTB entry holds valid, tag, target and a 2-bit counter.
REQ-017 SHALL declare a lookup hit when the indexed entry is valid and its tag matches, and predict taken when hit and counter[1]==1.
REQ-018 SHALL compute next_pc = predicted taken ? entry target : PC+INSTSIZE, with width DBITS and wrap modulo 2**DBITS.
REQ-019 SHALL update the PC register with priority reset > agex_mispred > de_stall > normal.
- On agex_mispred: PC <= agex_redirect_pc and fe_valid <= 0 (flush), regardless of de_stall.
- On de_stall without mispred: PC and all FE latch outputs hold.
- Otherwise: PC <= next_pc; latch <= {1, imem_data, PC, PC+INSTSIZE, pred_taken, next_pc, count}.
REQ-020 SHALL increment fe_inst_count by 1 on every cycle in which a valid instruction is latched, hold it on stall or flush, and wrap at 2**DBITS.
REQ-021 SHALL, when agex_br_valid is 1 and the entry indexed by agex_br_pc hits, saturate the counter up when taken (max 3) or down when not taken (min 0), and write agex_br_target when taken.
REQ-022 SHALL, when agex_br_valid is 1 and the entry misses, allocate it only if agex_br_taken: valid=1, new tag, target=agex_br_target, counter=2'b10; a not-taken miss SHALL leave the BTB unchanged.
REQ-023 SHALL perform BTB updates regardless of de_stall or agex_mispred.
REQ-024 SHALL, when an update and a lookup hit the same index in one cycle, return the pre-update contents to the lookup; the update becomes visible the next cycle.
REQ-025 SHALL ignore agex_br_* fields when agex_br_valid is 0.

Reset
REQ-026 SHALL, on reset, set PC=STARTPC, all FE latch outputs to 0, fe_inst_count=1, and all BTB valid bits to 0; target, tag and counter contents are don't-care.
REQ-027 SHALL let reset override a concurrent agex_mispred, de_stall or BTB update.
REQ-028 SHALL, on reset asserted mid-stream, restart fetch at STARTPC on the first cycle after reset deasserts, with no prediction surviving.

Verification
REQ-029 Sequential fetch: reset, then 3 cycles with no stall and an empty BTB -> fe_pc=0x200,0x204,0x208; fe_inst_count=1,2,3; fe_pred_taken=0.
REQ-030 Stall: de_stall=1 for 2 cycles while fe_pc=0x204 -> fe_pc, fe_inst and fe_inst_count hold; imem_addr holds at 0x208.
REQ-031 Allocate/predict: agex_br_valid=1, pc=0x208, taken=1, target=0x300; on the next fetch of 0x208 -> fe_pred_taken=1, fe_pred_target=0x300, next imem_addr=0x300.
REQ-032 Hysteresis: counter=2, two not-taken updates at 0x208 -> counter=0; fetch of 0x208 predicts not-taken with next PC 0x20C.
REQ-033 Mispredict under stall: agex_mispred=1, redirect=0x400, de_stall=1 -> next cycle imem_addr=0x400 and fe_valid=0; the following cycle fe_pc=0x400 and fe_valid=1.
REQ-034 Aliasing/same-cycle: with BTB_IDX_BITS=4, entry for 0x208 installed, fetch of 0x248 (same index, different tag) -> miss; a same-cycle update to the index being looked up -> old prediction this cycle, new prediction next cycle.
